// File: rtl/axis_s.sv
// AXI-Stream slave with a first-word-fall-through FIFO and packet tracking.
// Optional feature macro: AXIS_S_PKT_CNT_EN adds a 16-bit completed-packet counter output.
module axis_s #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              tvalid,
    output logic              tready,
    input  logic [DATA_W-1:0] tdata,
    input  logic              tlast,
    output logic [DATA_W-1:0] rdata,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rack,
    output logic              busy,
    output logic              received
`ifdef AXIS_S_PKT_CNT_EN
    ,
    output logic [15:0]       pkt_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_e;

    logic [DATA_W:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_e           state_q, state_d;
    logic             received_q, received_d;
    logic             push;
    logic             pop;
    logic [DATA_W:0]  head;

    // Valid/ready: a beat transfers on a rising edge where tvalid and tready are
    // both high; tready comes from the registered fill level (and reset) only, so
    // the master may hold tvalid with a stable beat until it is taken.
    assign tready = ~areset & (count_q != FULL_CNT);
    assign rvalid = (count_q != '0);
    assign push   = tvalid & tready;
    assign pop    = rvalid & rack;

    // Head is masked while empty so stale storage never reaches the outputs.
    assign head   = mem_q[rd_ptr_q];
    assign rdata  = rvalid ? head[DATA_W-1:0] : '0;
    assign rlast  = rvalid ? head[DATA_W] : 1'b0;

    // The FSM state is observable directly: busy is high exactly in ST_PKT.
    assign busy     = (state_q == ST_PKT);
    assign received = received_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        received_d = push & tlast;
        case (state_q)
            ST_IDLE: if (push && !tlast) state_d = ST_PKT;
            ST_PKT:  if (push && tlast)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            received_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            received_q <= received_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {tlast, tdata};
        end
    end

`ifdef AXIS_S_PKT_CNT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (push && tlast) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule
